// File: rtl/column_chunk_decoder.sv
// Column bitmap chunk decoder: collects one frame of CHUNK_W-bit chunks and
// reports the lowest marked row, plus empty-frame and multiple-mark flags.
module column_chunk_decoder #(
  parameter int ROWS    = 480,
  parameter int CHUNK_W = 16,
  parameter int IDX_W   = 10
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               frame_start,
  input  logic               chunk_valid,
  input  logic [CHUNK_W-1:0] chunk_data,
  output logic               chunk_ready,
  output logic               row_valid,
  output logic [IDX_W-1:0]   row_index,
  output logic               row_none,
  output logic               row_multi,
  output logic               frame_abort,
  output logic               busy
);

  localparam int NUM_CHUNKS = ROWS / CHUNK_W;
  localparam int CNT_W      = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;
  localparam int POS_W      = (CHUNK_W > 1) ? $clog2(CHUNK_W) : 1;
  localparam logic [CNT_W-1:0] LAST_CHUNK = CNT_W'(NUM_CHUNKS - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    REPORT  = 2'd2
  } state_t;

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   count, count_nxt;
  logic               found, found_nxt;
  logic               multi, multi_nxt;
  logic [IDX_W-1:0]   idx, idx_nxt;
  logic               row_valid_nxt, row_none_nxt, row_multi_nxt, frame_abort_nxt;
  logic [IDX_W-1:0]   row_index_nxt;

  logic               accept;
  logic               chunk_any, chunk_many, pos_hit;
  logic [POS_W-1:0]   low_pos;
  logic [IDX_W-1:0]   chunk_row;

  assign chunk_ready = (state == COLLECT) && !frame_start;
  assign busy        = (state != IDLE);
  assign accept      = chunk_valid && chunk_ready;

  // Priority scan from bit 0: the first set bit wins.
  always_comb begin
    low_pos = '0;
    pos_hit = 1'b0;
    for (int j = 0; j < CHUNK_W; j++) begin
      if (chunk_data[j] && !pos_hit) begin
        low_pos = POS_W'(j);
        pos_hit = 1'b1;
      end
    end
  end

  assign chunk_any  = |chunk_data;
  // Clearing the lowest set bit leaves something only if two or more were set.
  assign chunk_many = |(chunk_data & (chunk_data - CHUNK_W'(1)));
  assign chunk_row  = IDX_W'(count) * IDX_W'(CHUNK_W) + IDX_W'(low_pos);

  // NOTE: every output of this block gets a default first so no path leaves
  // a variable unassigned, which would otherwise infer a latch.
  always_comb begin
    state_nxt       = state;
    count_nxt       = count;
    found_nxt       = found;
    multi_nxt       = multi;
    idx_nxt         = idx;
    row_valid_nxt   = 1'b0;
    frame_abort_nxt = 1'b0;
    row_index_nxt   = row_index;
    row_none_nxt    = row_none;
    row_multi_nxt   = row_multi;

    unique case (state)
      IDLE: begin
        if (frame_start) begin
          state_nxt = COLLECT;
          count_nxt = '0;
          found_nxt = 1'b0;
          multi_nxt = 1'b0;
          idx_nxt   = '0;
        end
      end

      COLLECT: begin
        if (frame_start) begin
          frame_abort_nxt = 1'b1;
          count_nxt       = '0;
          found_nxt       = 1'b0;
          multi_nxt       = 1'b0;
          idx_nxt         = '0;
        end else if (accept) begin
          if (chunk_any) begin
            if (!found) begin
              idx_nxt   = chunk_row;
              found_nxt = 1'b1;
              multi_nxt = chunk_many;
            end else begin
              multi_nxt = 1'b1;
            end
          end
          if (count == LAST_CHUNK) begin
            // Results are registered on entry so they are valid throughout REPORT.
            state_nxt     = REPORT;
            row_valid_nxt = 1'b1;
            row_index_nxt = found_nxt ? idx_nxt : '0;
            row_none_nxt  = !found_nxt;
            row_multi_nxt = multi_nxt;
          end else begin
            count_nxt = count + CNT_W'(1);
          end
        end
      end

      REPORT: begin
        state_nxt = frame_start ? COLLECT : IDLE;
        count_nxt = '0;
        found_nxt = 1'b0;
        multi_nxt = 1'b0;
        idx_nxt   = '0;
      end

      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      count       <= '0;
      found       <= 1'b0;
      multi       <= 1'b0;
      idx         <= '0;
      row_valid   <= 1'b0;
      row_index   <= '0;
      row_none    <= 1'b0;
      row_multi   <= 1'b0;
      frame_abort <= 1'b0;
    end else begin
      state       <= state_nxt;
      count       <= count_nxt;
      found       <= found_nxt;
      multi       <= multi_nxt;
      idx         <= idx_nxt;
      row_valid   <= row_valid_nxt;
      row_index   <= row_index_nxt;
      row_none    <= row_none_nxt;
      row_multi   <= row_multi_nxt;
      frame_abort <= frame_abort_nxt;
    end
  end

endmodule
